// File: rtl/iter_func_unit.sv
// rtl/iter_func_unit.sv - multi-cycle functional unit: single-cycle ALU ops, iterative 1-bit-per-cycle shifts
module iter_func_unit #(
    parameter int SIZE  = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       FS,
    input  logic             BW,
    input  logic [SIZE-1:0]  A,
    input  logic [SIZE-1:0]  B,
    input  logic             Cin,
    input  logic [CNT_W-1:0] SHAMT,
    output logic             busy,
    output logic             done,
    output logic [SIZE-1:0]  F_out,
    output logic [3:0]       CVNZ_func
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [SIZE-1:0]  HALF_MASK = {{(SIZE/2){1'b0}}, {(SIZE/2){1'b1}}};
    localparam logic [SIZE-1:0]  FULL_MASK = {SIZE{1'b1}};
    localparam logic [SIZE-1:0]  HI_WORD   = {1'b1, {(SIZE-1){1'b0}}};
    localparam logic [SIZE-1:0]  HI_BYTE   = {{(SIZE/2){1'b0}}, 1'b1, {(SIZE/2-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [SIZE-1:0]  r_q;
    logic             c_q;
    logic [CNT_W-1:0] cnt_q;
    logic             bw_q;
    logic [1:0]       sop_q;

    logic alu_load, shift_load, shift_step, shift_last;

    logic unused_fs4;
    assign unused_fs4 = FS[4];

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        alu_load   = 1'b0;
        shift_load = 1'b0;
        shift_step = 1'b0;
        shift_last = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (!FS[5]) begin
                        alu_load = 1'b1;
                        state_d  = DONE;
                    end else begin
                        shift_load = 1'b1;
                        state_d    = SHIFT;
                    end
                end
            end
            SHIFT: begin
                shift_step = 1'b1;
                if (cnt_q == CNT_ONE) begin
                    shift_last = 1'b1;
                    state_d    = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ALU datapath: operands masked to the active width so the carry lands in bit W
    logic [SIZE-1:0] mask, hi, dst, src, src_op, alu_res, alu_res_m;
    logic [SIZE:0]   sum;
    logic            sub_op, cin_eff, alu_c, alu_v, alu_n, alu_z, sum_carry;
    logic            dst_s, src_s, sum_s;

    assign mask      = BW ? HALF_MASK : FULL_MASK;
    assign hi        = BW ? HI_BYTE : HI_WORD;
    assign dst       = B & mask;
    assign src       = A & mask;
    assign sub_op    = (FS[3:1] == 3'b001);
    assign src_op    = sub_op ? (~src & mask) : src;
    assign cin_eff   = (FS[3:0] == 4'd0) ? 1'b0 : (FS[3:0] == 4'd2) ? 1'b1 : Cin;
    assign sum       = {1'b0, dst} + {1'b0, src_op} + {{SIZE{1'b0}}, cin_eff};
    assign sum_carry = BW ? sum[SIZE/2] : sum[SIZE];
    assign dst_s     = |(dst & hi);
    assign src_s     = |(src_op & hi);
    assign sum_s     = |(sum[SIZE-1:0] & hi);

    always_comb begin
        alu_res = src;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (FS[3:0])
            4'd0, 4'd1, 4'd2, 4'd3: begin
                alu_res = sum[SIZE-1:0];
                alu_c   = sum_carry;
                alu_v   = (dst_s == src_s) && (sum_s != dst_s);
            end
            4'd4:    alu_res = dst & src;
            4'd5:    alu_res = dst | src;
            4'd6:    alu_res = dst ^ src;
            4'd7:    alu_res = dst & ~src;
            default: alu_res = src;
        endcase
        alu_res_m = alu_res & mask;
        alu_n     = |(alu_res_m & hi);
        alu_z     = (alu_res_m == '0);
        if (FS[3:0] >= 4'd4 && FS[3:0] <= 4'd7) alu_c = ~alu_z;
    end

    // One shift step on the working register, using the width captured at accept
    logic [SIZE-1:0] s_mask, s_hi, nr;
    logic            r_msb, nc;

    assign s_mask = bw_q ? HALF_MASK : FULL_MASK;
    assign s_hi   = bw_q ? HI_BYTE : HI_WORD;
    assign r_msb  = |(r_q & s_hi);

    always_comb begin
        nr = r_q;
        nc = c_q;
        case (sop_q)
            2'b00: begin nr = (r_q >> 1) | (c_q ? s_hi : '0);   nc = r_q[0]; end
            2'b01: begin nr = (r_q >> 1) | (r_msb ? s_hi : '0); nc = r_q[0]; end
            2'b10: begin nr = (r_q << 1) & s_mask;                                nc = r_msb; end
            default: begin nr = ((r_q << 1) | {{(SIZE-1){1'b0}}, c_q}) & s_mask; nc = r_msb; end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            F_out     <= '0;
            CVNZ_func <= '0;
            r_q       <= '0;
            c_q       <= 1'b0;
            cnt_q     <= '0;
            bw_q      <= 1'b0;
            sop_q     <= 2'b00;
        end else begin
            if (alu_load) begin
                F_out     <= alu_res_m;
                CVNZ_func <= {alu_c, alu_v, alu_n, alu_z};
            end
            if (shift_load) begin
                r_q   <= B & mask;
                c_q   <= Cin;
                cnt_q <= (SHAMT == '0) ? CNT_ONE : SHAMT;
                bw_q  <= BW;
                sop_q <= FS[1:0];
            end
            if (shift_step) begin
                r_q   <= nr;
                c_q   <= nc;
                cnt_q <= cnt_q - CNT_ONE;
            end
            if (shift_last) begin
                F_out     <= nr;
                CVNZ_func <= {nc, 1'b0, |(nr & s_hi), (nr == '0)};
            end
        end
    end

endmodule
